// File: rtl/scope_pkg.sv
// Shared constants and types for the scope-side waveform measurement blocks.
package scope_pkg;

  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] MID = 8'd128;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN
  } state_t;

  // Hysteresis thresholds around mid-scale; hyst is expected in 1..64 so
  // neither side can wrap.
  function automatic logic [SAMPLE_W-1:0] low_thr(input int hyst);
    logic [SAMPLE_W-1:0] h;
    h = hyst[SAMPLE_W-1:0];
    return MID - h;
  endfunction

  function automatic logic [SAMPLE_W-1:0] high_thr(input int hyst);
    logic [SAMPLE_W-1:0] h;
    h = hyst[SAMPLE_W-1:0];
    return MID + h;
  endfunction

endpackage

// File: rtl/wave_measure_if.sv
// Sample stream in, measurement results out, between a stream source and wave_measure.
interface wave_measure_if #(
  parameter int CNT_W = 16
) ();

  logic             in_valid;
  logic [7:0]       in_sample;
  logic [CNT_W-1:0] period;
  logic [7:0]       vmax;
  logic [7:0]       vmin;
  logic             meas_valid;
  logic             timeout;

  modport master (
    output in_valid,
    output in_sample,
    input  period,
    input  vmax,
    input  vmin,
    input  meas_valid,
    input  timeout
  );

  modport slave (
    input  in_valid,
    input  in_sample,
    output period,
    output vmax,
    output vmin,
    output meas_valid,
    output timeout
  );

endinterface

// File: rtl/wave_measure_cross_det.sv
// Hysteresis comparator: remembers whether the signal has been below the low
// threshold and flags the first valid sample at or above the high threshold.
module cross_det
  import scope_pkg::*;
#(
  parameter int HYST = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic                clear,
  output logic                rise
);

  localparam logic [SAMPLE_W-1:0] LO = low_thr(HYST);
  localparam logic [SAMPLE_W-1:0] HI = high_thr(HYST);

  logic below;

  // Track the below flag; clear (timeout) wins over a same-cycle low sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      below <= 1'b0;
    end else if (clear) begin
      below <= 1'b0;
    end else if (in_valid) begin
      if (in_sample < LO) begin
        below <= 1'b1;
      end else if (in_sample >= HI) begin
        below <= 1'b0;
      end
    end
  end

  assign rise = in_valid && below && (in_sample >= HI);

endmodule

// File: rtl/wave_measure.sv
// Period and per-cycle max/min measurement on rising mid-scale crossings.
module wave_measure
  import scope_pkg::*;
#(
  parameter int HYST  = 8,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  wave_measure_if.slave bus
);

  localparam logic [SAMPLE_W-1:0] LO = low_thr(HYST);

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [SAMPLE_W-1:0] accmax;
  logic [SAMPLE_W-1:0] accmin;

  logic [CNT_W-1:0]    period_q;
  logic [SAMPLE_W-1:0] vmax_q;
  logic [SAMPLE_W-1:0] vmin_q;
  logic                meas_valid_q;
  logic                timeout_q;

  logic rise;
  logic arm;
  logic sat;
  logic start_win;
  logic load_meas;
  logic count_en;
  logic do_timeout;

  cross_det #(
    .HYST(HYST)
  ) u_cross_det (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.in_valid),
    .in_sample(bus.in_sample),
    .clear    (do_timeout),
    .rise     (rise)
  );

  assign cnt_inc = cnt + 1'b1;
  // Saturation: the next count would land on the all-ones value.
  assign sat = (cnt_inc == {CNT_W{1'b1}});
  assign arm = bus.in_valid && (bus.in_sample < LO);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: arm on a low sample, start on a crossing, drop out on saturation.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm) state_next = ARMED;
      ARMED:   if (rise) state_next = RUN;
      RUN:     if (do_timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath controls; a crossing always beats a same-sample saturation.
  always_comb begin
    start_win  = 1'b0;
    load_meas  = 1'b0;
    count_en   = 1'b0;
    do_timeout = 1'b0;
    case (state)
      ARMED: begin
        start_win = rise;
      end
      RUN: begin
        start_win  = rise;
        load_meas  = rise;
        count_en   = bus.in_valid && !rise && !sat;
        do_timeout = bus.in_valid && !rise && sat;
      end
      default: ;
    endcase
  end

  // Counter, window accumulators and registered results.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt          <= '0;
      accmax       <= '0;
      accmin       <= '1;
      period_q     <= '0;
      vmax_q       <= '0;
      vmin_q       <= '1;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      meas_valid_q <= load_meas;
      timeout_q    <= do_timeout;
      if (load_meas) begin
        period_q <= cnt_inc;
        vmax_q   <= accmax;
        vmin_q   <= accmin;
      end
      if (start_win) begin
        cnt    <= '0;
        accmax <= bus.in_sample;
        accmin <= bus.in_sample;
      end else if (count_en) begin
        cnt <= cnt_inc;
        if (bus.in_sample > accmax) accmax <= bus.in_sample;
        if (bus.in_sample < accmin) accmin <= bus.in_sample;
      end
    end
  end

  assign bus.period     = period_q;
  assign bus.vmax       = vmax_q;
  assign bus.vmin       = vmin_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_wave_measure.sv
// Directed bench for wave_measure: a 16-bit-counter instance for the main
// scenarios and a 4-bit-counter instance, fed the same stream, for saturation.
module tb_wave_measure;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wave_measure_if #(.CNT_W(16)) bus_a ();
  wave_measure_if #(.CNT_W(4))  bus_b ();

  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_sample = bus_a.in_sample;

  wave_measure #(.HYST(8), .CNT_W(16)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  wave_measure #(.HYST(8), .CNT_W(4)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  typedef struct packed {
    logic        valid;
    logic [7:0]  sample;
    logic        exp_mv;
    logic [15:0] exp_period;
    logic [7:0]  exp_vmax;
    logic [7:0]  exp_vmin;
  } vec_t;

  vec_t vecs[30];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] sample);
    @(negedge clk);
    bus_a.in_valid  = valid;
    bus_a.in_sample = sample;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset          = 1'b0;
    bus_a.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic checkA(input string tag, input logic mv, input logic [15:0] p,
                        input logic [7:0] mx, input logic [7:0] mn);
    checkOutput({tag, "_mv"}, bus_a.meas_valid, mv);
    checkOutput({tag, "_period"}, bus_a.period, p);
    checkOutput({tag, "_vmax"}, bus_a.vmax, mx);
    checkOutput({tag, "_vmin"}, bus_a.vmin, mn);
  endtask

  task automatic checkB(input string tag, input logic mv, input logic to,
                        input logic [3:0] p, input logic [7:0] mx, input logic [7:0] mn);
    checkOutput({tag, "_mv"}, bus_b.meas_valid, mv);
    checkOutput({tag, "_to"}, bus_b.timeout, to);
    checkOutput({tag, "_period"}, bus_b.period, p);
    checkOutput({tag, "_vmax"}, bus_b.vmax, mx);
    checkOutput({tag, "_vmin"}, bus_b.vmin, mn);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int last;
    int pulses;
    int meas;
    int s;
    int c;
    logic [7:0] seq3[6];
    logic       mv3[6];
    logic [7:0] seq5[5];
    logic       mv5[5];

    reset           = 1'b1;
    bus_a.in_valid  = 1'b0;
    bus_a.in_sample = 8'd128;

    // Square stream 100x5 / 160x5: crossings at k=5,15,25; measurements at 15,25.
    for (int k = 0; k < 30; k++) begin
      vecs[k].valid      = 1'b1;
      vecs[k].sample     = ((k / 5) % 2 == 0) ? 8'd100 : 8'd160;
      vecs[k].exp_mv     = (k == 15) || (k == 25);
      vecs[k].exp_period = (k >= 15) ? 16'd10 : 16'd0;
      vecs[k].exp_vmax   = (k >= 15) ? 8'd160 : 8'd0;
      vecs[k].exp_vmin   = (k >= 15) ? 8'd100 : 8'd255;
    end

    doReset();
    checkA("rst", 1'b0, 16'd0, 8'd0, 8'd255);
    checkOutput("rst_to", bus_a.timeout, 0);
    checkB("rstb", 1'b0, 1'b0, 4'd0, 8'd0, 8'd255);

    for (int k = 0; k < 30; k++) begin
      applyStimulus(vecs[k].valid, vecs[k].sample);
      checkA("sq", vecs[k].exp_mv, vecs[k].exp_period, vecs[k].exp_vmax, vecs[k].exp_vmin);
      checkOutput("sq_to", bus_a.timeout, 0);
    end

    // Same stream with an idle cycle after every valid sample.
    doReset();
    cyc    = 0;
    last   = -1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, ((k / 5) % 2 == 0) ? 8'd100 : 8'd160);
      cyc++;
      if (bus_a.meas_valid) begin
        pulses++;
        checkOutput("gap_period", bus_a.period, 10);
        checkOutput("gap_vmax", bus_a.vmax, 160);
        checkOutput("gap_vmin", bus_a.vmin, 100);
        if (last >= 0) checkOutput("gap_spacing", cyc - last, 20);
        last = cyc;
      end
      applyStimulus(1'b0, 8'd200);
      cyc++;
      checkOutput("gap_idle_mv", bus_a.meas_valid, 0);
    end
    checkOutput("gap_pulses", pulses, 3);

    // Noise inside the hysteresis band after arming, then a clean step.
    doReset();
    applyStimulus(1'b1, 8'd100);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 8'(122 + (i % 13)));
      checkOutput("noise_mv", bus_a.meas_valid, 0);
    end
    seq3 = '{8'd100, 8'd200, 8'd200, 8'd200, 8'd100, 8'd200};
    mv3  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, seq3[i]);
      checkOutput("step_mv", bus_a.meas_valid, mv3[i]);
    end
    checkA("step", 1'b1, 16'd4, 8'd200, 8'd100);

    // 4-bit counter: measure once, then hold high until the counter saturates.
    doReset();
    applyStimulus(1'b1, 8'd100);
    applyStimulus(1'b1, 8'd200);
    applyStimulus(1'b1, 8'd100);
    applyStimulus(1'b1, 8'd200);
    checkB("sat_meas", 1'b1, 1'b0, 4'd2, 8'd200, 8'd100);
    // After the crossing cnt=0; the 15th further sample would bring cnt+1 to 15.
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1'b1, 8'd200);
      checkOutput("sat_to", bus_b.timeout, (i == 15));
      checkOutput("sat_mv", bus_b.meas_valid, 0);
    end
    applyStimulus(1'b1, 8'd200);
    checkB("sat_after", 1'b0, 1'b0, 4'd2, 8'd200, 8'd100);
    applyStimulus(1'b1, 8'd100);
    applyStimulus(1'b1, 8'd200);
    checkOutput("sat_rearm_mv", bus_b.meas_valid, 0);
    applyStimulus(1'b1, 8'd100);
    applyStimulus(1'b1, 8'd200);
    checkB("sat_remeas", 1'b1, 1'b0, 4'd2, 8'd200, 8'd100);

    // Reset in the middle of a running window dominates a crossing sample.
    doReset();
    applyStimulus(1'b1, 8'd100);
    applyStimulus(1'b1, 8'd100);
    applyStimulus(1'b1, 8'd160);
    applyStimulus(1'b1, 8'd160);
    applyStimulus(1'b1, 8'd100);
    applyStimulus(1'b1, 8'd100);
    applyStimulus(1'b1, 8'd160);
    checkA("pre_rst", 1'b1, 16'd4, 8'd160, 8'd100);
    applyStimulus(1'b1, 8'd160);
    applyStimulus(1'b1, 8'd100);
    @(negedge clk);
    reset           = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_sample = 8'd200;
    @(posedge clk);
    #1;
    checkA("mid_rst", 1'b0, 16'd0, 8'd0, 8'd255);
    checkOutput("mid_rst_to", bus_a.timeout, 0);
    @(negedge clk);
    reset = 1'b1;
    seq5 = '{8'd200, 8'd100, 8'd200, 8'd100, 8'd200};
    mv5  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, seq5[i]);
      checkOutput("post_rst_mv", bus_a.meas_valid, mv5[i]);
    end
    checkA("post_rst", 1'b1, 16'd2, 8'd200, 8'd100);

    // Magic-circle sine source, amplitude 30000, step 1/64 (period ~402 samples).
    doReset();
    s    = 0;
    c    = 30000;
    meas = 0;
    for (int n = 0; n < 4000 && meas < 5; n++) begin
      c = c - (s >>> 6);
      s = s + (c >>> 6);
      applyStimulus(1'b1, 8'(128 + (s >>> 8)));
      if (bus_a.meas_valid) begin
        meas++;
        checkOutput("sine_period_in_401_403",
                    (bus_a.period >= 16'd401) && (bus_a.period <= 16'd403), 1);
        checkOutput("sine_vmax_ge_240", bus_a.vmax >= 8'd240, 1);
        checkOutput("sine_vmin_le_16", bus_a.vmin <= 8'd16, 1);
        checkOutput("sine_to", bus_a.timeout, 0);
      end
    end
    checkOutput("sine_meas_count", meas, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
